// File: rtl/frame_swap_ctrl.sv
// -----------------------------------------------------------------------------
// frame_swap_ctrl
//
// Double-buffered frame bank controller. The compositor draws into the back
// bank while scan-out reads the front bank. When the compositor finishes a
// frame, the controller waits for the display frame boundary and then swaps
// the banks and launches the next draw. A frame boundary that arrives while
// drawing is still in progress is counted as a dropped frame.
//
// Ports
//   CLK                 system clock (single domain)
//   rst                 asynchronous active-high reset
//   pix_stb             pixel strobe
//   screenend           display is at the last pixel of the frame
//   i_is_layer_drawing  compositor busy flag
//   i_wr_en             compositor VRAM write request
//   i_draw_address      compositor bank-relative write address
//   i_disp_address      scan-out bank-relative read address
//   o_wr_en             gated VRAM write enable
//   o_wr_address        absolute write address (back bank)
//   o_rd_address        absolute read address (front bank)
//   o_front_bank        bank currently being displayed
//   o_start_draw        one-cycle compositor frame-start pulse
//   o_drop_cnt          saturating dropped-frame count
//   o_state             current state, for debug/LEDs
// -----------------------------------------------------------------------------
module frame_swap_ctrl #(
    parameter int VRAM_A_WIDTH   = 17,
    parameter int BANK_SIZE      = 57600,
    parameter int DROP_CNT_WIDTH = 8,
    parameter int START_TIMEOUT  = 1023
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      pix_stb,
    input  logic                      screenend,
    input  logic                      i_is_layer_drawing,
    input  logic                      i_wr_en,
    input  logic [VRAM_A_WIDTH-1:0]   i_draw_address,
    input  logic [VRAM_A_WIDTH-1:0]   i_disp_address,
    output logic                      o_wr_en,
    output logic [VRAM_A_WIDTH-1:0]   o_wr_address,
    output logic [VRAM_A_WIDTH-1:0]   o_rd_address,
    output logic                      o_front_bank,
    output logic                      o_start_draw,
    output logic [DROP_CNT_WIDTH-1:0] o_drop_cnt,
    output logic [1:0]                o_state
);

    localparam int TO_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT + 1);
    localparam logic [TO_W-1:0]           TO_LAST  = TO_W'(START_TIMEOUT);
    localparam logic [TO_W-1:0]           TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]           TO_ZERO  = TO_W'(0);
    localparam logic [VRAM_A_WIDTH-1:0]   BANK_OFS = VRAM_A_WIDTH'(BANK_SIZE);
    localparam logic [VRAM_A_WIDTH-1:0]   ADDR_ZERO = VRAM_A_WIDTH'(0);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ZERO = DROP_CNT_WIDTH'(0);

    typedef enum logic [1:0] {
        ST_LAUNCH    = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_DRAWING   = 2'd2,
        ST_READY     = 2'd3
    } state_t;

    state_t                      state_r;
    state_t                      state_s;
    logic                        front_bank_r;
    logic                        front_bank_s;
    logic [DROP_CNT_WIDTH-1:0]   drop_cnt_r;
    logic [DROP_CNT_WIDTH-1:0]   drop_cnt_s;
    logic [TO_W-1:0]             timeout_r;
    logic [TO_W-1:0]             timeout_s;
    logic                        drop_inc_s;
    logic                        fb_s;

    assign fb_s = pix_stb & screenend;

    // State, bank select, drop counter and start timeout registers.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_r      <= ST_LAUNCH;
            front_bank_r <= 1'b0;
            drop_cnt_r   <= DROP_ZERO;
            timeout_r    <= TO_ZERO;
        end else begin
            state_r      <= state_s;
            front_bank_r <= front_bank_s;
            drop_cnt_r   <= drop_cnt_s;
            timeout_r    <= timeout_s;
        end
    end

    // Next-state logic: launch, wait for busy, draw, wait for frame boundary.
    always_comb begin
        state_s      = state_r;
        front_bank_s = front_bank_r;
        timeout_s    = timeout_r;
        drop_inc_s   = 1'b0;
        case (state_r)
            ST_LAUNCH: begin
                // The timeout count restarts on every entry to WAIT_BUSY.
                state_s    = ST_WAIT_BUSY;
                timeout_s  = TO_ZERO;
                drop_inc_s = fb_s;
            end
            ST_WAIT_BUSY: begin
                drop_inc_s = fb_s;
                if (i_is_layer_drawing) begin
                    state_s = ST_DRAWING;
                end else if (timeout_r == TO_LAST) begin
                    // Compositor never acknowledged: re-issue the start pulse.
                    state_s = ST_LAUNCH;
                end else begin
                    timeout_s = timeout_r + TO_ONE;
                end
            end
            ST_DRAWING: begin
                if (!i_is_layer_drawing) begin
                    if (fb_s) begin
                        // Finished exactly on the boundary: swap, no drop.
                        front_bank_s = ~front_bank_r;
                        state_s      = ST_LAUNCH;
                    end else begin
                        state_s = ST_READY;
                    end
                end else begin
                    drop_inc_s = fb_s;
                end
            end
            ST_READY: begin
                if (fb_s) begin
                    front_bank_s = ~front_bank_r;
                    state_s      = ST_LAUNCH;
                end else begin
                    state_s = ST_READY;
                end
            end
            default: begin
                state_s = ST_LAUNCH;
            end
        endcase
    end

    // Saturating dropped-frame counter update.
    always_comb begin
        drop_cnt_s = drop_cnt_r;
        if (drop_inc_s && (drop_cnt_r != DROP_MAX)) begin
            drop_cnt_s = drop_cnt_r + DROP_ONE;
        end else begin
            drop_cnt_s = drop_cnt_r;
        end
    end

    // Output decode and bank-relative address translation.
    always_comb begin
        o_state      = state_r;
        o_front_bank = front_bank_r;
        o_drop_cnt   = drop_cnt_r;
        // Held low for the whole reset even though the state is LAUNCH.
        o_start_draw = (state_r == ST_LAUNCH) & ~rst;
        if ((state_r == ST_WAIT_BUSY) || (state_r == ST_DRAWING)) begin
            o_wr_en = i_wr_en;
        end else begin
            o_wr_en = 1'b0;
        end
        // Writes go to the bank not being displayed; reads to the front bank.
        if (front_bank_r) begin
            o_wr_address = i_draw_address + ADDR_ZERO;
            o_rd_address = i_disp_address + BANK_OFS;
        end else begin
            o_wr_address = i_draw_address + BANK_OFS;
            o_rd_address = i_disp_address + ADDR_ZERO;
        end
    end

endmodule

// File: tb/tb_frame_swap_ctrl.sv
module tb_frame_swap_ctrl;

    localparam int AW   = 17;
    localparam int BANK = 57600;
    localparam int TO   = 1023;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic          pix_stb = 1'b0;
    logic          screenend = 1'b0;
    logic          busy = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] draw_addr = '0;
    logic [AW-1:0] disp_addr = '0;

    logic          wr_en_a, fb_a, sd_a;
    logic [AW-1:0] wa_a, ra_a;
    logic [7:0]    drop_a;
    logic [1:0]    st_a;
    logic          wr_en_b, fb_b, sd_b;
    logic [AW-1:0] wa_b, ra_b;
    logic [1:0]    drop_b;
    logic [1:0]    st_b;

    int n_cmp = 0;
    int n_bad = 0;

    frame_swap_ctrl u_dut (
        .CLK(CLK), .rst(rst), .pix_stb(pix_stb), .screenend(screenend),
        .i_is_layer_drawing(busy), .i_wr_en(wr_en),
        .i_draw_address(draw_addr), .i_disp_address(disp_addr),
        .o_wr_en(wr_en_a), .o_wr_address(wa_a), .o_rd_address(ra_a),
        .o_front_bank(fb_a), .o_start_draw(sd_a), .o_drop_cnt(drop_a),
        .o_state(st_a)
    );

    frame_swap_ctrl #(.DROP_CNT_WIDTH(2)) u_dut2 (
        .CLK(CLK), .rst(rst), .pix_stb(pix_stb), .screenend(screenend),
        .i_is_layer_drawing(busy), .i_wr_en(wr_en),
        .i_draw_address(draw_addr), .i_disp_address(disp_addr),
        .o_wr_en(wr_en_b), .o_wr_address(wa_b), .o_rd_address(ra_b),
        .o_front_bank(fb_b), .o_start_draw(sd_b), .o_drop_cnt(drop_b),
        .o_state(st_b)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=launching, 1=waiting for busy, 2=drawing,
    // 3=finished and waiting for the frame boundary. Drops kept unbounded.
    int   m_phase = 0;
    int   m_wait  = 0;
    logic m_bank  = 1'b0;
    int   m_drops = 0;

    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_wait = 0; m_bank = 1'b0; m_drops = 0;
        end else begin
            if (m_phase == 0) begin
                if (pix_stb && screenend) m_drops++;
                m_phase = 1; m_wait = 0;
            end else if (m_phase == 1) begin
                if (pix_stb && screenend) m_drops++;
                if (busy) m_phase = 2;
                else if (m_wait == TO) m_phase = 0;
                else m_wait++;
            end else if (m_phase == 2) begin
                if (!busy && pix_stb && screenend) begin m_bank = ~m_bank; m_phase = 0; end
                else if (!busy) m_phase = 3;
                else if (pix_stb && screenend) m_drops++;
            end else begin
                if (pix_stb && screenend) begin m_bank = ~m_bank; m_phase = 0; end
            end
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        int exp_wa, exp_ra;
        exp_wa = (int'(draw_addr) + (m_bank ? 0 : BANK)) % (1 << AW);
        exp_ra = (int'(disp_addr) + (m_bank ? BANK : 0)) % (1 << AW);
        check("state",      st_a,    m_phase);
        check("start_draw", sd_a,    (m_phase == 0 && !rst) ? 1 : 0);
        check("front_bank", fb_a,    m_bank);
        check("drop_cnt",   drop_a,  sat(m_drops, 255));
        check("wr_en",      wr_en_a, (wr_en && (m_phase == 1 || m_phase == 2)) ? 1 : 0);
        check("wr_address", wa_a,    exp_wa);
        check("rd_address", ra_a,    exp_ra);
        check("state2",     st_b,    m_phase);
        check("front_bank2", fb_b,   m_bank);
        check("drop_cnt2",  drop_b,  sat(m_drops, 3));
        check("wr_address2", wa_b,   exp_wa);
        check("rd_address2", ra_b,   exp_ra);
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic fb_pulse();
        pix_stb = 1'b1; screenend = 1'b1;
        step(1);
        pix_stb = 1'b0; screenend = 1'b0;
    endtask

    initial begin
        int n;
        // Reset held: no start pulse.
        step(3);
        check("rst_start_draw", sd_a, 0);
        check("rst_state", st_a, 0);
        rst = 1'b0;
        #1;
        check("first_start_draw", sd_a, 1);

        // Normal frame: busy 3 cycles after start, 100 cycles drawing, fb 20 later.
        step(3);
        busy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_en = i[0];
            draw_addr = AW'(i);
            step(1);
        end
        busy = 1'b0;
        step(19);
        draw_addr = 17'd5; disp_addr = 17'd7; wr_en = 1'b1;
        #1;
        check("ready_state", st_a, 3);
        check("ready_wr_en_gated", wr_en_a, 0);
        check("wa_bank0", wa_a, 57605);
        check("ra_bank0", ra_a, 7);
        step(0);
        fb_pulse();
        check("swap_bank", fb_a, 1);
        check("swap_start", sd_a, 1);
        check("swap_drop", drop_a, 0);
        check("wa_bank1", wa_a, 5);
        check("ra_bank1", ra_a, 57607);
        wr_en = 1'b0;

        // Compositor stays busy across frame boundaries.
        busy = 1'b1;
        for (int p = 0; p < 5; p++) begin
            step(2);
            fb_pulse();
            if (p == 2) check("drop_after3", drop_a, 3);
        end
        check("drop_after5", drop_a, 5);
        check("drop2_saturated", drop_b, 3);
        check("busy_bank_held", fb_a, 1);

        // Busy falls on the same cycle as the boundary.
        busy = 1'b0; pix_stb = 1'b1; screenend = 1'b1;
        step(1);
        pix_stb = 1'b0; screenend = 1'b0;
        check("coinc_state", st_a, 0);
        check("coinc_bank", fb_a, 0);
        check("coinc_drop", drop_a, 5);

        // Compositor never goes busy: start re-issued periodically.
        n = 0;
        do begin
            step(1);
            n++;
            pix_stb = (n == 10); screenend = (n == 10);
        end while (!sd_a && n < 3000);
        pix_stb = 1'b0; screenend = 1'b0;
        check("timeout_period", n, TO + 2);
        check("wait_drop", drop_a, 6);

        // Reach DRAWING with bank 1, then reset asynchronously.
        busy = 1'b1;
        step(2);
        busy = 1'b0;
        step(1);
        fb_pulse();
        busy = 1'b1;
        step(2);
        check("pre_rst_state", st_a, 2);
        check("pre_rst_bank", fb_a, 1);
        #2 rst = 1'b1;
        #1;
        check("async_state", st_a, 0);
        check("async_bank", fb_a, 0);
        check("async_drop", drop_a, 0);
        check("async_start", sd_a, 0);
        busy = 1'b0;
        step(2);
        rst = 1'b0;
        #1;
        check("restart_start", sd_a, 1);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_swap_ctrl.md
FRAME_SWAP_CTRL -- requirements
Module: frame_swap_ctrl

Interface
REQ-001 SHALL have parameter VRAM_A_WIDTH, default 17, VRAM address width.
REQ-002 SHALL have parameter BANK_SIZE, default 57600, words per frame bank (320x180).
REQ-003 SHALL have parameter DROP_CNT_WIDTH, default 8, width of dropped-frame counter.
REQ-004 SHALL have parameter START_TIMEOUT, default 1023, max cycles waiting for compositor to go busy.
REQ-005 SHALL have ports:
- CLK  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- pix_stb  in  1  pixel strobe.
- screenend  in  1  display at last pixel of frame.
- i_is_layer_drawing  in  1  compositor busy flag.
- i_wr_en  in  1  compositor VRAM write request.
- i_draw_address  in  VRAM_A_WIDTH  compositor bank-relative write address.
- i_disp_address  in  VRAM_A_WIDTH  scan-out bank-relative read address.
- o_wr_en  out  1  gated VRAM write enable.
- o_wr_address  out  VRAM_A_WIDTH  absolute write address (back bank).
- o_rd_address  out  VRAM_A_WIDTH  absolute read address (front bank).
- o_front_bank  out  1  bank being displayed.
- o_start_draw  out  1  one-cycle compositor frame-start pulse.
- o_drop_cnt  out  DROP_CNT_WIDTH  saturating dropped-frame count.
- o_state  out  2  current state, debug/LED.

Function
REQ-006 SHALL define frame boundary fb = pix_stb & screenend.
REQ-007 SHALL implement states LAUNCH=0, WAIT_BUSY=1, DRAWING=2, READY=3.
REQ-008 LAUNCH: o_start_draw=1 for exactly this cycle; next state WAIT_BUSY unconditionally.
REQ-009 WAIT_BUSY: i_is_layer_drawing=1 -> DRAWING; else timeout counter increments; counter reaching START_TIMEOUT -> LAUNCH (re-issue start); counter clears on every entry to WAIT_BUSY.
REQ-010 DRAWING: i_is_layer_drawing=0 -> READY, except REQ-013.
REQ-011 READY: fb -> toggle o_front_bank and -> LAUNCH; else hold.
REQ-012 fb in LAUNCH, WAIT_BUSY or DRAWING (except REQ-013) SHALL increment o_drop_cnt, saturating at all-ones; no bank toggle.
REQ-013 DRAWING with i_is_layer_drawing=0 and fb same cycle SHALL toggle bank, go to LAUNCH, not count a drop.
REQ-014 o_wr_address SHALL be i_draw_address + (o_front_bank ? 0 : BANK_SIZE), combinational, truncated to VRAM_A_WIDTH.
REQ-015 o_rd_address SHALL be i_disp_address + (o_front_bank ? BANK_SIZE : 0), combinational.
REQ-016 o_wr_en SHALL be i_wr_en when state is WAIT_BUSY or DRAWING, else 0 (no writes to back bank once READY).
REQ-017 o_front_bank SHALL change only on the clock edge leaving READY or per REQ-013; the read/write bank pair never overlaps.
REQ-018 o_state SHALL equal state encoding; o_start_draw SHALL decode state LAUNCH only.

Reset
REQ-019 rst=1 SHALL asynchronously force state=LAUNCH, o_front_bank=0, o_drop_cnt=0, timeout counter=0.
REQ-020 While rst=1, o_start_draw SHALL be 0; first edge after release SHALL produce one o_start_draw cycle.
REQ-021 rst mid-frame SHALL abandon the current draw; no partial swap occurs.

Verification
REQ-022 Release reset, raise i_is_layer_drawing 3 cycles after o_start_draw, drop 100 cycles later, fb 20 cycles later -> o_front_bank 0->1, o_start_draw one cycle after, o_drop_cnt=0.
REQ-023 Hold compositor busy across 3 fb pulses -> o_drop_cnt=3, o_front_bank unchanged; set DROP_CNT_WIDTH=2, 5 fb pulses -> o_drop_cnt=3.
REQ-024 Busy falls same cycle as fb -> bank toggles, state LAUNCH next, o_drop_cnt unchanged.
REQ-025 Never raise busy -> o_start_draw repeats every START_TIMEOUT+2 cycles; o_wr_en stays gated only in READY/LAUNCH.
REQ-026 o_front_bank=0, i_draw_address=5, i_disp_address=7 -> o_wr_address=57605, o_rd_address=7; after swap -> 5, 57607.
REQ-027 Assert rst in DRAWING with o_front_bank=1, o_drop_cnt=2 -> immediately state=0, bank=0, drop=0 without clock edge.
